// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with 3-sample majority vote and a one-byte holding register.
// Latency: rx_valid rises 1 clk after the stop-bit mid-sample tick, plus 2 clks of input synchronisation.
// Backpressure: holding register waits on rx_ready; a byte completing while it is still full is dropped and flagged as overrun.
module uart_rx_os #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    // Clocks per oversample tick; the divider must be at least 2 for the
    // tick to be a single-cycle event.
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchroniser stages; idle-high so reset does not look like a start bit.
    logic rxd_m;
    logic rxd_s;

    // Oversampling timebase
    logic [DW-1:0] div_cnt;
    logic [3:0]    samp_cnt;
    logic          run;
    logic          tick;
    logic          bit_end;
    logic          mid_done;

    // Mid-bit samples taken at samp_cnt 7, 8 and 9
    logic [2:0] smp;
    logic       vote_bit;
    logic       vote_stop;

    // Data path
    logic [2:0] bit_idx;
    logic [7:0] shift;

    // Controls produced by the FSM
    logic cnt_clr;
    logic shift_en;
    logic bit_clr;
    logic bit_inc;
    logic deliver;
    logic ferr_evt;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // The timebase only runs while a frame is being tracked; in IDLE it is
    // held at zero so the first tick lands DIV clocks after the falling edge.
    assign run      = (state == START) || (state == DATA) || (state == STOP);
    assign tick     = run && (div_cnt == DIV_LAST);
    assign bit_end  = tick && (samp_cnt == 4'd15);
    assign mid_done = tick && (samp_cnt == 4'd9);

    // Full-bit decisions use the three stored samples. The stop bit is
    // decided on the tick that takes the third sample, so that sample is
    // taken straight from the line rather than from the register.
    assign vote_bit  = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign vote_stop = (smp[0] & smp[1]) | (smp[0] & rxd_s) | (smp[1] & rxd_s);

    // Clock divider producing one tick every DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (cnt_clr) begin
            div_cnt <= '0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Sample position within the current bit; wraps 15 -> 0 at bit boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= 4'd0;
        end else if (cnt_clr) begin
            samp_cnt <= 4'd0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
        end
    end

    // Capture the three mid-bit samples used by the majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= 3'b000;
        end else if (cnt_clr) begin
            smp <= 3'b000;
        end else if (tick) begin
            case (samp_cnt)
                4'd7:    smp[0] <= rxd_s;
                4'd8:    smp[1] <= rxd_s;
                4'd9:    smp[2] <= rxd_s;
                default: smp    <= smp;
            endcase
        end
    end

    // Data bit index within the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (cnt_clr || bit_clr) begin
            bit_idx <= 3'd0;
        end else if (bit_inc) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // LSB-first shift register: each voted bit enters at the top and moves down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 8'h00;
        end else if (shift_en) begin
            shift <= {vote_bit, shift[7:1]};
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        deliver   = 1'b0;
        ferr_evt  = 1'b0;
        case (state)
            IDLE: begin
                // Counters sit cleared so the falling edge becomes sample 0
                cnt_clr = 1'b1;
                if (!rxd_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    if (!vote_bit) begin
                        state_nxt = DATA;
                        bit_clr   = 1'b1;
                    end else begin
                        // Short low pulse: not a real start bit
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Decide mid-stop-bit so a start bit that immediately follows
                // the stop bit is seen from IDLE.
                if (mid_done) begin
                    if (vote_stop) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_evt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line or break must return high before re-arming
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Holding register with valid/ready handshake and overrun detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else begin
                if (deliver) begin
                    // Register still owned by the consumer: drop the new byte
                    overrun <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

    // Framing error pulse, one clock per bad stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_evt;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: drives serial frames on rxd and scores delivered bytes.
// Expected bytes are queued when their frame is sent and popped on each handshake.
// Error pulses are counted and compared per scenario.
module tb_uart_rx_os;

    localparam int BIT      = 434;
    localparam int BIT_FAST = 425;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int rx_cnt   = 0;

    logic [7:0] exp_q[$];

    uart_rx_os #(
        .CLK_FREQ (50000000),
        .BAUD_RATE(115200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; the line is left at the stop-bit level afterwards
    task automatic send_byte(input logic [7:0] d, input int cpb, input logic stop_bit);
        rxd = 1'b0;
        wait_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(cpb);
        end
        rxd = stop_bit;
        wait_clks(cpb);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            wait_clks(1);
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: compare every accepted byte, count error pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                rx_cnt++;
                check("rx_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err || overrun) begin
                check("err_exclusive", 32'(frame_err && overrun), 32'd0);
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
            end
        end
    end

    initial begin
        int fe0, ov0, rx0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        rst_n    = 1'b0;
        wait_clks(3);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_clks(2 * BIT);

        // Single byte
        fe0 = fe_cnt; ov0 = ov_cnt; rx0 = rx_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, BIT, 1'b1);
        wait_clks(BIT);
        wait_drain("t1_drain");
        check("t1_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("t1_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Back-to-back frames, no idle between stop and next start
        fe0 = fe_cnt; ov0 = ov_cnt; rx0 = rx_cnt;
        foreach (exp_q[i]) begin end
        begin
            logic [7:0] seq [5];
            seq = '{8'hA5, 8'h3C, 8'h7F, 8'h00, 8'hFF};
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(seq[i]);
                send_byte(seq[i], BIT, 1'b1);
            end
        end
        wait_clks(BIT);
        wait_drain("t2_drain");
        check("t2_rx_count", 32'(rx_cnt - rx0), 32'd5);
        check("t2_errors", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // Glitch rejection, then a fast (+2%) transmitter
        fe0 = fe_cnt; rx0 = rx_cnt;
        rxd = 1'b0;
        wait_clks(5);
        rxd = 1'b1;
        wait_clks(2 * BIT);
        check("t3_glitch_rx", 32'(rx_cnt - rx0), 32'd0);
        check("t3_glitch_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t3_glitch_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_FAST, 1'b1);
        wait_clks(BIT);
        wait_drain("t3_drain");
        check("t3_rx_count", 32'(rx_cnt - rx0), 32'd1);

        // Framing error with the line held low, then recovery
        fe0 = fe_cnt; rx0 = rx_cnt;
        send_byte(8'h55, BIT, 1'b0);
        wait_clks(2 * BIT);
        rxd = 1'b1;
        wait_clks(BIT);
        check("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("t4_no_delivery", 32'(rx_cnt - rx0), 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT, 1'b1);
        wait_clks(BIT);
        wait_drain("t4_drain");
        check("t4_rx_count", 32'(rx_cnt - rx0), 32'd1);

        // Overrun while the holding register is not drained
        ov0 = ov_cnt; fe0 = fe_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, BIT, 1'b1);
        wait_clks(BIT);
        check("t5_valid_held", 32'(rx_valid), 32'd1);
        check("t5_data_first", 32'(rx_data), 32'h11);
        check("t5_no_overrun_yet", 32'(ov_cnt - ov0), 32'd0);
        send_byte(8'h22, BIT, 1'b1);
        wait_clks(BIT);
        check("t5_overrun", 32'(ov_cnt - ov0), 32'd1);
        check("t5_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("t5_valid_still", 32'(rx_valid), 32'd1);
        check("t5_data_stable", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        check("t5_valid_fell", 32'(rx_valid), 32'd0);
        check("t5_data_kept", 32'(rx_data), 32'h11);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        rx_ready = 1'b1;
        wait_clks(BIT);

        // Reset during data bit 4 of 0x81
        rx0 = rx_cnt;
        rxd = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = (i == 0) ? 1'b1 : 1'b0;
            wait_clks(BIT);
        end
        rxd = 1'b0;
        wait_clks(BIT / 2);
        rst_n = 1'b0;
        wait_clks(1);
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_data", 32'(rx_data), 32'h00);
        check("t6_rst_frame_err", 32'(frame_err), 32'd0);
        check("t6_rst_overrun", 32'(overrun), 32'd0);
        wait_clks(1);
        rxd = 1'b1;
        wait_clks(1);
        rst_n = 1'b1;
        wait_clks(2 * BIT);
        check("t6_no_partial", 32'(rx_cnt - rx0), 32'd0);
        exp_q.push_back(8'h7F);
        send_byte(8'h7F, BIT, 1'b1);
        wait_clks(BIT);
        wait_drain("t6_drain");
        check("t6_rx_count", 32'(rx_cnt - rx0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: the serial-to-byte stage directly downstream of the `rxd` pin in `uart_top`.
- Synchronises `rxd` and detects the start bit.
- Recovers 8N1 frames by 3-sample majority vote.
- Presents each byte on a valid/ready handshake to the receive FIFO, and flags framing errors and overruns.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate.
DIV (localparam), CLK_FREQ/(BAUD_RATE*16) truncated = 27, clocks per oversample tick; must be >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
rxd  input  1  serial input, idle high, asynchronous to clk.
rx_data  output  8  received byte; valid while rx_valid=1.
rx_valid  output  1  byte available in holding register.
rx_ready  input  1  consumer accepts; transfer when rx_valid&&rx_ready.
frame_err  output  1  one-cycle pulse: stop bit sampled 0.
overrun  output  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0; synchroniser flops=1; state=IDLE; all counters=0.
- Input sync: 2-flop synchroniser on rxd; all decisions use the synchronised `rxd_s` (2-clk latency).
- Tick generator:
  - div_cnt counts 0..DIV-1 and emits tick at DIV-1.
  - It is forced to 0 on start detection, so bit sampling aligns to the falling edge.
- Sample counter: samp_cnt 0..15 per bit, advancing on tick.
- Majority vote: samples at samp_cnt 7, 8 and 9; bit = majority of the three.
- State machine:
  - IDLE: rxd_s==0 -> START; clear div_cnt, samp_cnt and the vote samples.
  - START: at samp_cnt 15 tick:
    - vote==0 -> DATA, bit_idx=0.
    - vote==1 -> IDLE (glitch rejected, no outputs).
  - DATA:
    - Each bit's vote shifts into shift reg LSB-first.
    - At samp_cnt 15 tick, bit_idx increments; after bit_idx==7 -> STOP.
  - STOP: on the tick at samp_cnt 9 (vote complete) evaluate immediately, without waiting out the bit:
    - vote==1 -> deliver byte; go to IDLE.
    - vote==0 -> frame_err=1 for one clk; byte discarded; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1, then IDLE. A held-low line or break never produces a new frame until the line returns high.
- Delivery and holding register:
  - If rx_valid==0, or the handshake completes in the same cycle: rx_data<=byte, rx_valid<=1.
  - Else: overrun=1 for one clk; the new byte is dropped; rx_data/rx_valid are unchanged.
- Handshake: rx_valid falls on the cycle after rx_valid&&rx_ready unless a new byte loads that cycle. rx_data is stable while rx_valid=1 and not yet accepted.
- Latency: rx_valid rises one clk after the stop-bit samp_cnt 9 tick, about 9.6/16 of a bit into the stop bit, plus 2 sync clks.
- Back-to-back frames: returning to IDLE mid-stop-bit guarantees detection of a start bit immediately following the stop bit.
- Baud tolerance: bytes are received correctly with transmitter rate error up to ±2%.
- Reset mid-frame:
  - All state clears immediately.
  - No partial byte is ever delivered.
  - After release, the block behaves as from power-up; the bench releases reset only with the line idle high.
- frame_err and overrun never assert in the same cycle; each is a single-cycle pulse per event.

Test Plan:
- 50 MHz clk, 434 clk/bit (8680 ns), rx_ready=1, send 0xA5 -> one rx_valid pulse with rx_data=0xA5; frame_err=0, overrun=0.
- Bytes 0xA5, 0x3C, 0x7F, 0x00, 0xFF sent with zero idle between stop and next start, rx_ready=1 -> five deliveries in order with exact values; no errors.
- rxd low for 5 clks (100 ns) then high -> START rejected, returns to IDLE; no rx_valid, no frame_err. Then 0x3C at 425 clk/bit (+2%) -> rx_data=0x3C.
- 0x55 with stop bit 0, line held low 2 more bit times, then high, then 0x3C -> one frame_err pulse; no delivery for 0x55; next delivery rx_data=0x3C.
- rx_ready=0, send 0x11 then 0x22 -> rx_data holds 0x11, rx_valid=1, one overrun pulse at the 0x22 stop bit. Then rx_ready=1 for one clk -> rx_valid=0 next cycle, rx_data unchanged.
- rst_n low for 3 clks during data bit 4 of 0x81, line then idled high, then 0x7F -> outputs at reset values during reset; no delivery of 0x81; rx_data=0x7F delivered.
